// File: rtl/cache_mem_pkg.sv
// rtl/cache_mem_pkg.sv - shared constants and types for the cache line memory slave
package cache_mem_pkg;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_LINE_W = 128;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_RD_LAT = 2;
    localparam int MAX_RD_LAT = 8;
    localparam int CH_ID_W    = 4;

    typedef logic [CH_ID_W-1:0] ch_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, priority moves past the last granted requester
module rr_arbiter
    import cache_mem_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output ch_id_t       grant_idx,
    output logic         grant_any
);

    ch_id_t ptr;

    // First pass looks at requesters at or above the pointer, second pass wraps around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!grant_any && req[i] && (ch_id_t'(i) >= ptr)) begin
                grant[i]  = 1'b1;
                grant_idx = ch_id_t'(i);
                grant_any = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!grant_any && req[i]) begin
                grant[i]  = 1'b1;
                grant_idx = ch_id_t'(i);
                grant_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (grant_idx == ch_id_t'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_slave.sv
// rtl/cache_mem_slave.sv - multi-channel line memory with arbitrated access and fixed read latency
module cache_mem_slave
    import cache_mem_pkg::*;
#(
    parameter int    NUM_CH       = DEF_NUM_CH,
    parameter int    LINE_W       = DEF_LINE_W,
    parameter int    ADDR_W       = DEF_ADDR_W,
    parameter int    DEPTH        = DEF_DEPTH,
    parameter int    RD_LAT       = DEF_RD_LAT,
    parameter int    STALL_PERIOD = 0,
    parameter string INIT_FILE    = ""
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]    ch_addr,
    input  logic [NUM_CH-1:0][LINE_W/8-1:0]  ch_byte_en,
    input  logic [NUM_CH-1:0][LINE_W-1:0]    ch_writedata,
    input  logic [NUM_CH-1:0]                ch_read,
    input  logic [NUM_CH-1:0]                ch_write,
    output logic [NUM_CH-1:0][LINE_W-1:0]    ch_readdata,
    output logic [NUM_CH-1:0]                ch_readdata_valid,
    output logic [NUM_CH-1:0]                ch_waitrequest
);

    localparam int BE_W  = LINE_W / 8;
    localparam int OFS   = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        ch_id_t            id;
        logic [LINE_W-1:0] data;
    } rd_slot_t;

    logic [LINE_W-1:0]              mem [DEPTH];
    rd_slot_t                       pipe [RD_LAT];
    rd_slot_t                       last_slot;
    logic [NUM_CH-1:0][LINE_W-1:0]  hold;

    logic [31:0]       stall_cnt;
    logic              stall;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] grant;
    ch_id_t            grant_idx;
    logic              grant_any;

    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [LINE_W-1:0] sel_wdata;
    logic              sel_rd;
    logic              sel_wr;
    logic [IDX_W-1:0]  line_idx;
    logic              wr_fire;
    logic              rd_fire;
    logic              unused_addr_bits;

    assign stall = (STALL_PERIOD > 0) && (stall_cnt == 32'(STALL_PERIOD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (STALL_PERIOD > 0) begin
            stall_cnt <= stall ? '0 : stall_cnt + 32'd1;
        end
    end

    // Nothing is granted during reset or a stall cycle, so memory cannot be written then.
    assign req            = ch_read | ch_write;
    assign arb_req        = (rst && !stall) ? req : '0;
    assign ch_waitrequest = (!rst || stall) ? '1 : (req & ~grant);

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_addr  = ch_addr[i];
                sel_be    = ch_byte_en[i];
                sel_wdata = ch_writedata[i];
                sel_rd    = ch_read[i];
                sel_wr    = ch_write[i];
            end
        end
    end

    // Offset and upper address bits do not select a line; the address wraps over DEPTH lines.
    assign line_idx         = sel_addr[OFS +: IDX_W];
    assign unused_addr_bits = ^sel_addr;
    assign wr_fire          = grant_any & sel_wr;
    assign rd_fire          = grant_any & sel_rd & ~sel_wr;

    // Memory has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < BE_W; b++) begin
                if (sel_be[b]) begin
                    mem[line_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: rd_fire, id: grant_idx, data: mem[line_idx]};
            for (int k = 1; k < RD_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign last_slot = pipe[RD_LAT-1];

    always_comb begin
        ch_readdata_valid = '0;
        ch_readdata       = hold;
        for (int i = 0; i < NUM_CH; i++) begin
            if (last_slot.valid && (last_slot.id == ch_id_t'(i))) begin
                ch_readdata_valid[i] = 1'b1;
                ch_readdata[i]       = last_slot.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold <= '0;
        end else begin
            hold <= ch_readdata;
        end
    end

endmodule
